srl_tap_delay: RTL

- Parametrised, clock-enabled multi-bit shift register with a run-time selectable output tap and fill tracking.
- Successor to the fixed 8-stage single-bit chain used in SRL inference tests.
- Generalises width and depth, adds a dynamic tap address in the style of SRLC32E, and adds an optional output register.
- Sits in the synth_xilinx_srl test set as the reference design for dynamic-tap and enable-gated SRL mapping.

---
 rtl/srl_fill_tracker.sv | 28 ++
 rtl/srl_tap_delay.sv | 87 ++++++++
 2 files changed

// File: rtl/srl_fill_tracker.sv
// Saturating fill counter: counts the enabled edges since reset, up to DEPTH.
module srl_fill_tracker #(
  parameter  int DEPTH = 8,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  output logic [CNTW-1:0] fill,
  output logic            full
);

  localparam logic [CNTW-1:0] LP_DEPTH = CNTW'(DEPTH);

  logic [CNTW-1:0] r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (ce && (r_fill != LP_DEPTH)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  assign fill = r_fill;
  assign full = (r_fill == LP_DEPTH);

endmodule

// File: rtl/srl_tap_delay.sv
// Enable-gated multi-bit shift register with a run-time tap select, fill
// tracking and an optional registered output.
module srl_tap_delay #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  parameter  int OREG  = 0,
  localparam int TAPW  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] i,
  input  logic [TAPW-1:0]  tap,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CNTW-1:0]  fill,
  output logic             full
);

  // One bit wider than tap so DEPTH itself is representable for the range check.
  localparam logic [TAPW:0] LP_DEPTH_T = (TAPW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CNTW-1:0]  w_fill;
  logic             w_full;
  logic             w_tap_ok;
  logic [WIDTH-1:0] w_tap_q;
  logic             w_tap_vld;

  // Stage p0: the shift chain itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else if (ce) begin
      r_stage[0] <= i;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  srl_fill_tracker #(
    .DEPTH (DEPTH)
  ) u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .fill  (w_fill),
    .full  (w_full)
  );

  // A tap past the last stage (non power-of-two DEPTH) reads as invalid zero.
  assign w_tap_ok  = ({1'b0, tap} < LP_DEPTH_T);
  assign w_tap_q   = w_tap_ok ? r_stage[tap] : '0;
  assign w_tap_vld = w_tap_ok && (w_fill > CNTW'(tap));

  // Stage p1: optional output register, loads every edge regardless of ce
  generate
    if (OREG != 0) begin : g_oreg
      logic [WIDTH-1:0] r_q_p1;
      logic             r_vld_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q_p1   <= '0;
          r_vld_p1 <= 1'b0;
        end else begin
          r_q_p1   <= w_tap_q;
          r_vld_p1 <= w_tap_vld;
        end
      end

      assign q       = r_q_p1;
      assign q_valid = r_vld_p1;
    end else begin : g_comb
      assign q       = w_tap_q;
      assign q_valid = w_tap_vld;
    end
  endgenerate

  assign fill = w_fill;
  assign full = w_full;

endmodule
